multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Multi-cycle control unit for the RV32I core. It replaces single-cycle decode with a state machine that sequences fetch, decode, execute, memory and write-back. It drives the existing datapath selects and ALU op, and handshakes with instruction and data memories that may take several cycles. It adds JALR, LUI and AUIPC, a memory timeout, illegal-instruction trapping and a retired-instruction counter.

Parameters:
ALU_OP_W, 4, width of alu_op
WB_SEL_W, 2, width of sel_wb (0 mem, 1 alu, 2 pc+4, 3 imm)
MEM_TIMEOUT, 16, maximum cycles a memory request may wait for ack; 0 disables the timeout
CNT_W, 32, width of instret

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
inst_i  in  32  instruction read data, valid when imem_ack_i=1
imem_ack_i  in  1  instruction memory ack
dmem_ack_i  in  1  data memory ack
br_taken_i  in  1  comparator result for the current branch
imem_req  out  1  instruction fetch request
ir_wr  out  1  latch inst_i into the datapath IR
dmem_req  out  1  data request
mem_rd  out  1  load
mem_wr  out  1  store
mask  out  3  funct3 of the load/store
reg_wr  out  1  register file write
sel_a  out  1  0 rs1, 1 pc
sel_b  out  1  0 rs2, 1 imm
alu_op  out  ALU_OP_W  ALU operation
sel_wb  out  WB_SEL_W  write-back source
br_type  out  3  branch funct3
pc_wr  out  1  PC update
pc_sel  out  2  0 pc+4, 1 registered alu_out, 2 live ALU result
trap  out  1  sticky; illegal instruction or memory timeout
trap_cause  out  2  0 none, 1 illegal, 2 imem timeout, 3 dmem timeout
instret  out  CNT_W  retired-instruction count, wraps modulo 2^CNT_W

Behaviour:
- States: RST, FETCH, DECODE, EXEC, MEM, WB, HALT. The async reset sets state=RST, IR=0, counters=0 and trap_cause=0.
- During and after reset, every output is 0 until FETCH is entered.
- RST moves to FETCH after exactly one cycle.
- Outputs are decoded from the registered state and IR only; there is no combinational path from inst_i to the control outputs.
- FETCH:
  - imem_req=1 until imem_ack_i.
  - On the ack cycle, ir_wr=1, IR<=inst_i and the next state is DECODE.
- DECODE:
  - One cycle, no side effects.
  - An illegal IR goes to HALT with cause 1.
  - Illegal means: unknown opcode; R-type funct7 other than 0x00/0x20; 0x20 with funct3 other than 000/101; load funct3 in {3,6,7}; store funct3 >2; branch funct3 in {2,3}.
- EXEC:
  - R and I-arith: sel_b=0 for R, 1 for I. ALU codes: ADD 0, XOR 1, OR 2, AND 3, SLL 4, SRL 5, SRA 6, SLT 7, SLTU 8, SUB 9, PASS_B 10. Next state WB.
  - LUI: alu_op=PASS_B, sel_b=1. Next state WB.
  - AUIPC, JAL: sel_a=1, sel_b=1, ADD. Next state WB.
  - JALR: sel_a=0, sel_b=1, ADD. Next state WB.
  - Load/store: sel_b=1, ADD. Next state MEM.
  - Branch: sel_a=1, sel_b=1, ADD, br_type=funct3, pc_wr=1, pc_sel = br_taken_i ? 2 : 0, retire. Next state FETCH.
- MEM:
  - dmem_req=1, and mem_rd or mem_wr held with it; mask=funct3 held stable until ack.
  - Load ack goes to WB.
  - Store ack asserts pc_wr=1, pc_sel=0, retires and goes to FETCH.
- WB:
  - reg_wr=1 and pc_wr=1.
  - sel_wb: 0 for load, 1 for R/I/AUIPC, 2 for JAL/JALR, 3 for LUI.
  - pc_sel=1 for JAL/JALR, else 0. The datapath clears bit 0 for JALR.
  - Retires, then FETCH.
- Latency with same-cycle ack:
  - ALU ops, JAL, JALR, LUI, AUIPC: 4 cycles.
  - Loads: 5 cycles.
  - Stores: 4 cycles.
  - Branches: 3 cycles.
- Timeout:
  - A counter clears on entry to FETCH/MEM and increments each cycle the request waits.
  - When it reaches MEM_TIMEOUT without ack, go to HALT with cause 2 (FETCH) or 3 (MEM).
  - An ack in the same cycle as the limit wins.
- HALT: trap=1, all other outputs 0, exited only by reset.
- Retire: instret increments by 1 in the retire cycle; it is never incremented for a trapped instruction.
- Reset mid-instruction: abort immediately; no partial reg_wr or pc_wr.

Decomposition:
- Shared package ctrl_pkg holds:
  - opcode constants
  - the alu_op enum (values above)
  - the wb_sel, pc_sel and trap_cause enums
  - the state enum
  - the instruction field struct
- One sub-module, ctrl_decode: combinational IR -> {class, alu_op, sel_wb, illegal}, instantiated once.
- The FSM, timeout counter and instret stay in the top module.

Test Plan:
- ADD 0x002081B3, ack same cycle -> states FETCH, DECODE, EXEC, WB. In EXEC, alu_op=0, sel_b=0. In WB, reg_wr=1, sel_wb=1, pc_wr=1, pc_sel=0. instret 0->1.
- LW funct3=010 with dmem_ack_i delayed 3 cycles -> dmem_req/mem_rd held 4 cycles with mask=2, then WB with sel_wb=0. Total 8 cycles.
- BEQ with br_taken_i=1, then with br_taken_i=0 -> pc_wr in EXEC with pc_sel=2 and 0 respectively. reg_wr never 1.
- JALR 0x000080E7 -> WB with sel_wb=2, pc_sel=1, reg_wr=1. LUI 0x123450B7 -> alu_op=10, sel_wb=3.
- Opcode 0x7F, and SUB with funct3=001 -> HALT, trap=1, trap_cause=1, instret unchanged, stays halted for 100 cycles. rst_i then returns to RST.
- imem_ack_i withheld with MEM_TIMEOUT=16 -> after 16 waiting cycles, trap_cause=2. A rerun with ack arriving on the 16th cycle gives no trap. Asserting rst_i mid-MEM clears all outputs the same cycle.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types for the RV32I multi-cycle control unit: opcodes, select encodings,
// FSM states and the instruction field layout.
package ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_I      = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_XOR    = 4'd1,
    ALU_OR     = 4'd2,
    ALU_AND    = 4'd3,
    ALU_SLL    = 4'd4,
    ALU_SRL    = 4'd5,
    ALU_SRA    = 4'd6,
    ALU_SLT    = 4'd7,
    ALU_SLTU   = 4'd8,
    ALU_SUB    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_MEM = 2'd0,
    WB_ALU = 2'd1,
    WB_PC4 = 2'd2,
    WB_IMM = 2'd3
  } wb_sel_e;

  typedef enum logic [1:0] {
    PC_PLUS4    = 2'd0,
    PC_ALU_REG  = 2'd1,
    PC_ALU_LIVE = 2'd2
  } pc_sel_e;

  typedef enum logic [1:0] {
    TC_NONE    = 2'd0,
    TC_ILLEGAL = 2'd1,
    TC_IMEM    = 2'd2,
    TC_DMEM    = 2'd3
  } trap_cause_e;

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  typedef enum logic [3:0] {
    CLS_R      = 4'd0,
    CLS_I      = 4'd1,
    CLS_LOAD   = 4'd2,
    CLS_STORE  = 4'd3,
    CLS_BRANCH = 4'd4,
    CLS_JAL    = 4'd5,
    CLS_JALR   = 4'd6,
    CLS_LUI    = 4'd7,
    CLS_AUIPC  = 4'd8
  } inst_class_e;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } inst_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction classifier: maps the latched IR to an instruction
// class, ALU operation, write-back source and an illegal-instruction flag.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  inst_t       ir_i,
  output inst_class_e cls_o,
  output alu_op_e     alu_op_o,
  output wb_sel_e     sel_wb_o,
  output logic        illegal_o
);

  alu_op_e base_op;
  logic    unused_fields;

  // Register operands and rd are consumed by the datapath, not by control.
  assign unused_fields = ^{ir_i.rs1, ir_i.rs2, ir_i.rd};

  always_comb begin
    case (ir_i.funct3)
      3'd0:    base_op = ALU_ADD;
      3'd1:    base_op = ALU_SLL;
      3'd2:    base_op = ALU_SLT;
      3'd3:    base_op = ALU_SLTU;
      3'd4:    base_op = ALU_XOR;
      3'd5:    base_op = ALU_SRL;
      3'd6:    base_op = ALU_OR;
      default: base_op = ALU_AND;
    endcase
  end

  always_comb begin
    cls_o     = CLS_R;
    alu_op_o  = ALU_ADD;
    sel_wb_o  = WB_ALU;
    illegal_o = 1'b0;
    case (ir_i.opcode)
      OP_R: begin
        cls_o    = CLS_R;
        alu_op_o = base_op;
        if (ir_i.funct7 == 7'h20) begin
          if (ir_i.funct3 == 3'd0) begin
            alu_op_o = ALU_SUB;
          end else if (ir_i.funct3 == 3'd5) begin
            alu_op_o = ALU_SRA;
          end else begin
            illegal_o = 1'b1;
          end
        end else if (ir_i.funct7 != 7'h00) begin
          illegal_o = 1'b1;
        end
      end
      OP_I: begin
        cls_o    = CLS_I;
        alu_op_o = base_op;
        // SRAI is distinguished from SRLI by instruction bit 30.
        if (ir_i.funct3 == 3'd5 && ir_i.funct7[5]) begin
          alu_op_o = ALU_SRA;
        end
      end
      OP_LOAD: begin
        cls_o     = CLS_LOAD;
        sel_wb_o  = WB_MEM;
        illegal_o = (ir_i.funct3 == 3'd3) || (ir_i.funct3 == 3'd6) || (ir_i.funct3 == 3'd7);
      end
      OP_STORE: begin
        cls_o     = CLS_STORE;
        illegal_o = (ir_i.funct3 > 3'd2);
      end
      OP_BRANCH: begin
        cls_o     = CLS_BRANCH;
        illegal_o = (ir_i.funct3 == 3'd2) || (ir_i.funct3 == 3'd3);
      end
      OP_JAL: begin
        cls_o    = CLS_JAL;
        sel_wb_o = WB_PC4;
      end
      OP_JALR: begin
        cls_o    = CLS_JALR;
        sel_wb_o = WB_PC4;
      end
      OP_LUI: begin
        cls_o    = CLS_LUI;
        alu_op_o = ALU_PASS_B;
        sel_wb_o = WB_IMM;
      end
      OP_AUIPC: begin
        cls_o = CLS_AUIPC;
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/write-back,
// handles memory handshakes with timeout, illegal-instruction trap and instret.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int ALU_OP_W    = 4,
  parameter int WB_SEL_W    = 2,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [31:0]         inst_i,
  input  logic                imem_ack_i,
  input  logic                dmem_ack_i,
  input  logic                br_taken_i,
  output logic                imem_req,
  output logic                ir_wr,
  output logic                dmem_req,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic [2:0]          mask,
  output logic                reg_wr,
  output logic                sel_a,
  output logic                sel_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [WB_SEL_W-1:0] sel_wb,
  output logic [2:0]          br_type,
  output logic                pc_wr,
  output logic [1:0]          pc_sel,
  output logic                trap,
  output logic [1:0]          trap_cause,
  output logic [CNT_W-1:0]    instret
);

  localparam int              TMO_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);
  localparam bit              TMO_EN   = (MEM_TIMEOUT != 0);

  state_e             state_q, state_d;
  inst_t              ir_q, ir_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [CNT_W-1:0]   instret_q, instret_d;
  trap_cause_e        cause_q, cause_d;
  logic               retire;

  inst_class_e        dec_cls;
  alu_op_e            dec_alu;
  wb_sel_e            dec_wb;
  logic               dec_illegal;

  ctrl_decode u_decode (
    .ir_i      (ir_q),
    .cls_o     (dec_cls),
    .alu_op_o  (dec_alu),
    .sel_wb_o  (dec_wb),
    .illegal_o (dec_illegal)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_RST;
      ir_q      <= '0;
      tmo_q     <= '0;
      instret_q <= '0;
      cause_q   <= TC_NONE;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      tmo_q     <= tmo_d;
      instret_q <= instret_d;
      cause_q   <= cause_d;
    end
  end

  // The wait counter is zero outside FETCH/MEM, so each entry starts it from zero.
  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    tmo_d    = '0;
    cause_d  = cause_q;
    retire   = 1'b0;
    imem_req = 1'b0;
    ir_wr    = 1'b0;
    dmem_req = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    mask     = '0;
    reg_wr   = 1'b0;
    sel_a    = 1'b0;
    sel_b    = 1'b0;
    alu_op   = '0;
    sel_wb   = '0;
    br_type  = '0;
    pc_wr    = 1'b0;
    pc_sel   = '0;
    trap     = 1'b0;
    case (state_q)
      ST_RST: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack_i) begin
          ir_wr   = 1'b1;
          ir_d    = inst_t'(inst_i);
          state_d = ST_DECODE;
        end else if (TMO_EN && tmo_q == TMO_LAST) begin
          state_d = ST_HALT;
          cause_d = TC_IMEM;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_DECODE: begin
        if (dec_illegal) begin
          state_d = ST_HALT;
          cause_d = TC_ILLEGAL;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_op  = ALU_OP_W'(dec_alu);
        state_d = ST_WB;
        case (dec_cls)
          CLS_I, CLS_LUI, CLS_JALR: begin
            sel_b = 1'b1;
          end
          CLS_AUIPC, CLS_JAL: begin
            sel_a = 1'b1;
            sel_b = 1'b1;
          end
          CLS_LOAD, CLS_STORE: begin
            sel_b   = 1'b1;
            state_d = ST_MEM;
          end
          CLS_BRANCH: begin
            sel_a   = 1'b1;
            sel_b   = 1'b1;
            br_type = ir_q.funct3;
            pc_wr   = 1'b1;
            pc_sel  = br_taken_i ? PC_ALU_LIVE : PC_PLUS4;
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
          default: begin
            sel_b = 1'b0;
          end
        endcase
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        mem_rd   = (dec_cls == CLS_LOAD);
        mem_wr   = (dec_cls == CLS_STORE);
        mask     = ir_q.funct3;
        if (dmem_ack_i) begin
          if (dec_cls == CLS_STORE) begin
            pc_wr   = 1'b1;
            pc_sel  = PC_PLUS4;
            retire  = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else if (TMO_EN && tmo_q == TMO_LAST) begin
          state_d = ST_HALT;
          cause_d = TC_DMEM;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_WB: begin
        reg_wr  = 1'b1;
        pc_wr   = 1'b1;
        sel_wb  = WB_SEL_W'(dec_wb);
        pc_sel  = (dec_cls == CLS_JAL || dec_cls == CLS_JALR) ? PC_ALU_REG : PC_PLUS4;
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_HALT: begin
        trap = 1'b1;
      end
      default: begin
        state_d = ST_RST;
      end
    endcase
  end

  assign instret_d  = instret_q + CNT_W'(retire);
  assign instret    = instret_q;
  assign trap_cause = cause_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed and random instructions compared cycle by
// cycle against a phase-level reference model of the control unit.
module tb_multicycle_ctrl;

  localparam int TMO = 16;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] inst_i = '0;
  logic        imem_ack_i = 1'b0;
  logic        dmem_ack_i = 1'b0;
  logic        br_taken_i = 1'b0;
  logic        imem_req, ir_wr, dmem_req, mem_rd, mem_wr, reg_wr, sel_a, sel_b, pc_wr, trap;
  logic [2:0]  mask, br_type;
  logic [3:0]  alu_op;
  logic [1:0]  sel_wb, pc_sel, trap_cause;
  logic [31:0] instret;

  multicycle_ctrl #(
    .ALU_OP_W(4), .WB_SEL_W(2), .MEM_TIMEOUT(TMO), .CNT_W(32)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .inst_i(inst_i), .imem_ack_i(imem_ack_i),
    .dmem_ack_i(dmem_ack_i), .br_taken_i(br_taken_i), .imem_req(imem_req),
    .ir_wr(ir_wr), .dmem_req(dmem_req), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mask(mask), .reg_wr(reg_wr), .sel_a(sel_a), .sel_b(sel_b), .alu_op(alu_op),
    .sel_wb(sel_wb), .br_type(br_type), .pc_wr(pc_wr), .pc_sel(pc_sel),
    .trap(trap), .trap_cause(trap_cause), .instret(instret)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic       imem_req, ir_wr, dmem_req, mem_rd, mem_wr;
    logic [2:0] mask;
    logic       reg_wr, sel_a, sel_b;
    logic [3:0] alu_op;
    logic [1:0] sel_wb;
    logic [2:0] br_type;
    logic       pc_wr;
    logic [1:0] pc_sel;
    logic       trap;
  } ctl_t;

  typedef struct {
    bit          iack, dack, btk;
    logic [31:0] inst;
    ctl_t        o;
    logic [31:0] ret;
    logic [1:0]  cause;
  } step_t;

  ctl_t        obs;
  step_t       exp_q[$];
  logic [31:0] exp_ret = '0;
  int          halt_len = 5;
  int          n_cmp = 0;
  int          n_fail = 0;

  assign obs = {imem_req, ir_wr, dmem_req, mem_rd, mem_wr, mask, reg_wr, sel_a, sel_b,
                alu_op, sel_wb, br_type, pc_wr, pc_sel, trap};

  // ---------------- reference model ----------------
  function automatic string classify(input logic [31:0] in);
    logic [2:0] f3 = in[14:12];
    logic [6:0] f7 = in[31:25];
    case (in[6:0])
      7'h33: return (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) ? "R" : "BAD";
      7'h13: return "I";
      7'h03: return (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) ? "BAD" : "LD";
      7'h23: return (f3 > 3'd2) ? "BAD" : "ST";
      7'h63: return (f3 == 3'd2 || f3 == 3'd3) ? "BAD" : "BR";
      7'h6F: return "JAL";
      7'h67: return "JALR";
      7'h37: return "LUI";
      7'h17: return "AUIPC";
      default: return "BAD";
    endcase
  endfunction

  function automatic logic [3:0] exp_alu(input logic [31:0] in, input string k);
    logic [3:0] tbl [8];
    logic [2:0] f3 = in[14:12];
    tbl = '{4'd0, 4'd4, 4'd7, 4'd8, 4'd1, 4'd5, 4'd2, 4'd3};
    if (k == "LUI") return 4'd10;
    if (k == "R" && in[31:25] == 7'h20) return (f3 == 3'd0) ? 4'd9 : 4'd6;
    if (k == "R") return tbl[f3];
    if (k == "I") return (f3 == 3'd5 && in[30]) ? 4'd6 : tbl[f3];
    return 4'd0;
  endfunction

  function automatic void push(input bit ia, input bit da, input bit bt,
                               input logic [31:0] in, input ctl_t c, input logic [1:0] cause);
    step_t s;
    s.iack = ia; s.dack = da; s.btk = bt; s.inst = in; s.o = c; s.ret = exp_ret; s.cause = cause;
    exp_q.push_back(s);
  endfunction

  function automatic void halt_tail(input logic [1:0] cause);
    ctl_t c;
    c = '0;
    c.trap = 1'b1;
    for (int i = 0; i < halt_len; i++) push(1'b0, 1'b0, 1'b0, 32'h0, c, cause);
  endfunction

  // Expands one instruction into its per-cycle expected control outputs; returns 1 if it traps.
  function automatic bit model(input logic [31:0] in, input int idly, input int ddly, input bit tk);
    string      k = classify(in);
    logic [2:0] f3 = in[14:12];
    bit         jump = (k == "JAL" || k == "JALR");
    ctl_t       c;
    c = '0; c.imem_req = 1'b1;
    for (int i = 0; i < idly && i < TMO; i++) push(1'b0, 1'b0, tk, in, c, 2'd0);
    if (idly >= TMO) begin halt_tail(2'd2); return 1'b1; end
    c.ir_wr = 1'b1;
    push(1'b1, 1'b0, tk, in, c, 2'd0);
    c = '0;
    push(1'b0, 1'b0, tk, in, c, 2'd0);
    if (k == "BAD") begin halt_tail(2'd1); return 1'b1; end
    c.alu_op = exp_alu(in, k);
    c.sel_a  = (k == "AUIPC" || k == "JAL" || k == "BR");
    c.sel_b  = (k != "R");
    if (k == "BR") begin
      c.br_type = f3; c.pc_wr = 1'b1; c.pc_sel = tk ? 2'd2 : 2'd0;
      push(1'b0, 1'b0, tk, in, c, 2'd0);
      exp_ret++;
      return 1'b0;
    end
    push(1'b0, 1'b0, tk, in, c, 2'd0);
    if (k == "LD" || k == "ST") begin
      c = '0; c.dmem_req = 1'b1; c.mem_rd = (k == "LD"); c.mem_wr = (k == "ST"); c.mask = f3;
      for (int i = 0; i < ddly && i < TMO; i++) push(1'b0, 1'b0, tk, in, c, 2'd0);
      if (ddly >= TMO) begin halt_tail(2'd3); return 1'b1; end
      if (k == "ST") begin
        c.pc_wr = 1'b1;
        push(1'b0, 1'b1, tk, in, c, 2'd0);
        exp_ret++;
        return 1'b0;
      end
      push(1'b0, 1'b1, tk, in, c, 2'd0);
    end
    c = '0; c.reg_wr = 1'b1; c.pc_wr = 1'b1;
    c.sel_wb = (k == "LD") ? 2'd0 : jump ? 2'd2 : (k == "LUI") ? 2'd3 : 2'd1;
    c.pc_sel = jump ? 2'd1 : 2'd0;
    push(1'b0, 1'b0, tk, in, c, 2'd0);
    exp_ret++;
    return 1'b0;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] in = $urandom();
    int          r  = $urandom_range(0, 9);
    case ($urandom_range(0, 9))
      0: begin
        in[6:0] = 7'h33;
        in[31:25] = (r < 5) ? 7'h00 : (r < 9) ? 7'h20 : 7'($urandom());
      end
      1: in[6:0] = 7'h13;
      2: in[6:0] = 7'h03;
      3: in[6:0] = 7'h23;
      4: in[6:0] = 7'h63;
      5: in[6:0] = 7'h6F;
      6: in[6:0] = 7'h67;
      7: in[6:0] = 7'h37;
      8: in[6:0] = 7'h17;
      default: in[6:0] = 7'($urandom());
    endcase
    return in;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive(input step_t e);
    @(posedge clk_i);
    #1;
    imem_ack_i = e.iack;
    dmem_ack_i = e.dack;
    br_taken_i = e.btk;
    inst_i     = e.iack ? e.inst : $urandom();
    #4;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    imem_ack_i = 1'b0; dmem_ack_i = 1'b0; br_taken_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    #4;
    exp_ret = '0;
    exp_q.delete();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    step_t e;
    rst_i = 1'b1; imem_ack_i = 1'b1; dmem_ack_i = 1'b1; br_taken_i = 1'b1; inst_i = 32'h002081B3;
    repeat (3) @(posedge clk_i);
    #5;
    n_cmp++;
    if (obs !== '0 || instret !== 32'd0 || trap_cause !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_hold: ctl=%h instret=%0d cause=%0d, expected all zero", obs, instret, trap_cause);
    end
    @(posedge clk_i);
    #1;
    imem_ack_i = 1'b0; dmem_ack_i = 1'b0; br_taken_i = 1'b0; rst_i = 1'b0;
    #4;
    n_cmp++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL reset_rst_state: ctl=%h, expected 0", obs);
    end
    exp_ret = '0;
    void'(model(32'h002081B3, 0, 0, 1'b0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      drive(e);
      n_cmp++;
      if (obs !== e.o || instret !== e.ret || trap_cause !== e.cause) begin
        n_fail++;
        $display("FAIL reset_first_fetch: ctl=%h instret=%0d cause=%0d, expected ctl=%h instret=%0d cause=%0d",
                 obs, instret, trap_cause, e.o, e.ret, e.cause);
      end
    end
  endtask

  task automatic test_add();
    step_t e;
    do_reset();
    void'(model(32'h002081B3, 0, 0, 1'b0));
    void'(model(32'h002081B3, 1, 0, 1'b1));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      drive(e);
      n_cmp++;
      if (obs !== e.o || instret !== e.ret || trap_cause !== e.cause) begin
        n_fail++;
        $display("FAIL add: ctl=%h instret=%0d cause=%0d, expected ctl=%h instret=%0d cause=%0d",
                 obs, instret, trap_cause, e.o, e.ret, e.cause);
      end
    end
    @(posedge clk_i);
    #5;
    n_cmp++;
    if (instret !== 32'd2) begin
      n_fail++;
      $display("FAIL add_instret: got %0d, expected 2", instret);
    end
  endtask

  task automatic test_load_store();
    step_t e;
    do_reset();
    void'(model(32'h0020A183, 0, 3, 1'b0));
    void'(model(32'h0020A023, 2, 1, 1'b1));
    void'(model(32'h002081B3, 0, 0, 1'b0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      drive(e);
      n_cmp++;
      if (obs !== e.o || instret !== e.ret || trap_cause !== e.cause) begin
        n_fail++;
        $display("FAIL load_store: ctl=%h instret=%0d cause=%0d, expected ctl=%h instret=%0d cause=%0d",
                 obs, instret, trap_cause, e.o, e.ret, e.cause);
      end
    end
  endtask

  task automatic test_branch_jump();
    step_t e;
    do_reset();
    void'(model(32'h00208463, 0, 0, 1'b1));
    void'(model(32'h00208463, 0, 0, 1'b0));
    void'(model(32'h000080E7, 0, 0, 1'b0));
    void'(model(32'h123450B7, 0, 0, 1'b1));
    void'(model(32'h008000EF, 0, 0, 1'b0));
    void'(model(32'h00001097, 0, 0, 1'b0));
    void'(model(32'h4020D133, 0, 0, 1'b0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      drive(e);
      n_cmp++;
      if (obs !== e.o || instret !== e.ret || trap_cause !== e.cause) begin
        n_fail++;
        $display("FAIL branch_jump: ctl=%h instret=%0d cause=%0d, expected ctl=%h instret=%0d cause=%0d",
                 obs, instret, trap_cause, e.o, e.ret, e.cause);
      end
    end
  endtask

  task automatic test_illegal();
    step_t e;
    do_reset();
    halt_len = 100;
    void'(model(32'h002081B3, 0, 0, 1'b0));
    void'(model(32'h0000007F, 0, 0, 1'b0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      drive(e);
      n_cmp++;
      if (obs !== e.o || instret !== e.ret || trap_cause !== e.cause) begin
        n_fail++;
        $display("FAIL illegal_opcode: ctl=%h instret=%0d cause=%0d, expected ctl=%h instret=%0d cause=%0d",
                 obs, instret, trap_cause, e.o, e.ret, e.cause);
      end
    end
    halt_len = 5;
    rst_i = 1'b1;
    #1;
    n_cmp++;
    if (obs !== '0 || trap_cause !== 2'd0 || instret !== 32'd0) begin
      n_fail++;
      $display("FAIL halt_reset: ctl=%h cause=%0d instret=%0d, expected all zero", obs, trap_cause, instret);
    end
    do_reset();
    void'(model(32'h40209133, 0, 0, 1'b0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      drive(e);
      n_cmp++;
      if (obs !== e.o || instret !== e.ret || trap_cause !== e.cause) begin
        n_fail++;
        $display("FAIL illegal_sub: ctl=%h instret=%0d cause=%0d, expected ctl=%h instret=%0d cause=%0d",
                 obs, instret, trap_cause, e.o, e.ret, e.cause);
      end
    end
  endtask

  task automatic test_timeout();
    step_t e;
    for (int run = 0; run < 4; run++) begin
      do_reset();
      case (run)
        0: void'(model(32'h002081B3, TMO, 0, 1'b0));
        1: begin
          void'(model(32'h002081B3, TMO - 1, 0, 1'b0));
          void'(model(32'h002081B3, 0, 0, 1'b0));
        end
        2: void'(model(32'h0020A183, 0, TMO, 1'b0));
        default: begin
          void'(model(32'h0020A023, 0, TMO - 1, 1'b0));
          void'(model(32'h002081B3, 0, 0, 1'b0));
        end
      endcase
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        drive(e);
        n_cmp++;
        if (obs !== e.o || instret !== e.ret || trap_cause !== e.cause) begin
          n_fail++;
          $display("FAIL timeout_run%0d: ctl=%h instret=%0d cause=%0d, expected ctl=%h instret=%0d cause=%0d",
                   run, obs, instret, trap_cause, e.o, e.ret, e.cause);
        end
      end
    end
  endtask

  task automatic test_reset_mid_mem();
    step_t e;
    do_reset();
    void'(model(32'h002081B3, 0, 0, 1'b0));
    void'(model(32'h0020A183, 0, 10, 1'b0));
    for (int i = 0; i < 9; i++) begin
      e = exp_q.pop_front();
      drive(e);
      n_cmp++;
      if (obs !== e.o || instret !== e.ret || trap_cause !== e.cause) begin
        n_fail++;
        $display("FAIL mid_mem_pre: ctl=%h instret=%0d cause=%0d, expected ctl=%h instret=%0d cause=%0d",
                 obs, instret, trap_cause, e.o, e.ret, e.cause);
      end
    end
    exp_q.delete();
    dmem_ack_i = 1'b1;
    rst_i = 1'b1;
    #1;
    n_cmp++;
    if (obs !== '0 || instret !== 32'd0 || trap_cause !== 2'd0) begin
      n_fail++;
      $display("FAIL mid_mem_reset: ctl=%h instret=%0d cause=%0d, expected all zero", obs, instret, trap_cause);
    end
  endtask

  task automatic test_random();
    step_t       e;
    logic [31:0] in;
    int          idly, ddly;
    bit          halted;
    do_reset();
    for (int n = 0; n < 300; n++) begin
      in     = rand_inst();
      idly   = ($urandom_range(0, 39) == 0) ? TMO : $urandom_range(0, 3);
      ddly   = ($urandom_range(0, 39) == 0) ? TMO : $urandom_range(0, 3);
      halted = model(in, idly, ddly, 1'($urandom()));
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        drive(e);
        n_cmp++;
        if (obs !== e.o || instret !== e.ret || trap_cause !== e.cause) begin
          n_fail++;
          $display("FAIL random inst=%h: ctl=%h instret=%0d cause=%0d, expected ctl=%h instret=%0d cause=%0d",
                   in, obs, instret, trap_cause, e.o, e.ret, e.cause);
        end
      end
      if (halted) do_reset();
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_load_store();
    test_branch_jump();
    test_illegal();
    test_timeout();
    test_reset_mid_mem();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
